fpnew_result_packer: RTL and testbench

// Encoder counterpart of the operand classifier. Takes a decomposed result
// (sign, biased exponent, mantissa, result kind) plus rounding mode and packs
// it into an IEEE bit pattern of FpFormat:
// - specials, canonical NaN and overflow saturation handled here
// - NaN-boxed into a Width-bit register word

---
 rtl/fpnew_result_packer.sv | 164 ++++++++++++++++
 tb/tb_fpnew_result_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_result_packer.sv
// fpnew_result_packer
// Packs a decomposed FP result (sign, biased exponent, rounded mantissa, kind)
// into an IEEE bit pattern of the selected format. Specials, the canonical
// quiet NaN and overflow saturation are resolved here. The packed value is
// NaN-boxed into a Width-bit word and sent through a stall-able valid/ready
// pipeline of NumPipeRegs stages.
//
// FpFormat encoding: 0=FP32 1=FP64 2=FP16 3=FP8 4=FP16ALT.
// Round modes: 0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM; any other code acts as RNE.
// Status bits: {NV, DZ, OF, UF, NX}.
module fpnew_result_packer #(
    parameter int unsigned FpFormat    = 0,
    parameter int unsigned Width       = 64,
    parameter int unsigned NumPipeRegs = 1,
    parameter int unsigned TagWidth    = 4,
    localparam int unsigned EXP_BITS   = (FpFormat == 1) ? 11 :
                                         (FpFormat == 2 || FpFormat == 3) ? 5 : 8,
    localparam int unsigned MAN_BITS   = (FpFormat == 0) ? 23 :
                                         (FpFormat == 1) ? 52 :
                                         (FpFormat == 2) ? 10 :
                                         (FpFormat == 3) ? 2  : 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                sign_i,
    input  logic [EXP_BITS:0]   exponent_i,
    input  logic [MAN_BITS-1:0] mantissa_i,
    input  logic [1:0]          kind_i,
    input  logic [2:0]          rnd_mode_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    result_o,
    output logic [4:0]          status_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                busy_o
);

    localparam int unsigned WIDTH = 1 + EXP_BITS + MAN_BITS;
    localparam int unsigned DW    = Width + 5 + TagWidth;

    localparam logic [1:0] KIND_NUM  = 2'd0;
    localparam logic [1:0] KIND_ZERO = 2'd1;
    localparam logic [1:0] KIND_INF  = 2'd2;
    localparam logic [1:0] KIND_NAN  = 2'd3;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // First exponent value that no longer fits a finite number.
    localparam logic [EXP_BITS:0]   EXP_OVF  = {1'b0, {EXP_BITS{1'b1}}};
    localparam logic [EXP_BITS-1:0] EXP_ONES = {EXP_BITS{1'b1}};
    localparam logic [EXP_BITS-1:0] EXP_MAXN = {{(EXP_BITS-1){1'b1}}, 1'b0};
    localparam logic [MAN_BITS-1:0] MAN_ZERO = {MAN_BITS{1'b0}};
    localparam logic [MAN_BITS-1:0] MAN_ONES = {MAN_BITS{1'b1}};
    localparam logic [MAN_BITS-1:0] MAN_QNAN = {1'b1, {(MAN_BITS-1){1'b0}}};

    logic [2:0]       w_rm;
    logic             w_ovf_inf;
    logic [WIDTH-1:0] w_val;
    logic [4:0]       w_status;
    logic [Width-1:0] w_res;
    logic [DW-1:0]    w_pk;

    // Overflow direction: round toward the infinity on the sign's side,
    // saturate to max-normal when rounding toward zero from that side.
    always_comb begin
        w_rm      = (rnd_mode_i > RM_RMM) ? RM_RNE : rnd_mode_i;
        w_ovf_inf = 1'b0;
        case (w_rm)
            RM_RNE, RM_RMM: w_ovf_inf = 1'b1;
            RM_RTZ:         w_ovf_inf = 1'b0;
            RM_RDN:         w_ovf_inf = sign_i;
            RM_RUP:         w_ovf_inf = ~sign_i;
            default:        w_ovf_inf = 1'b1;
        endcase
    end

    // Encode the result kind into a bit pattern and raise OF|NX on overflow.
    always_comb begin
        w_val    = '0;
        w_status = '0;
        case (kind_i)
            KIND_ZERO: w_val = {sign_i, {EXP_BITS{1'b0}}, MAN_ZERO};
            KIND_INF:  w_val = {sign_i, EXP_ONES, MAN_ZERO};
            KIND_NAN:  w_val = {1'b0, EXP_ONES, MAN_QNAN};
            default: begin
                if (exponent_i >= EXP_OVF) begin
                    w_status = 5'b00101;
                    w_val    = w_ovf_inf ? {sign_i, EXP_ONES, MAN_ZERO}
                                         : {sign_i, EXP_MAXN, MAN_ONES};
                end else begin
                    w_val = {sign_i, exponent_i[EXP_BITS-1:0], mantissa_i};
                end
            end
        endcase
    end

    // Upper bits of the register word are the NaN-box.
    if (Width > WIDTH) begin : g_box
        assign w_res = {{(Width - WIDTH){1'b1}}, w_val};
    end else begin : g_nobox
        assign w_res = w_val;
    end

    assign w_pk = {w_res, w_status, tag_i};

    if (NumPipeRegs == 0) begin : g_comb
        logic w_unused;
        assign w_unused                      = ^{clk_i, rst_ni, flush_i};
        assign in_ready_o                    = out_ready_i;
        assign out_valid_o                   = in_valid_i;
        assign {result_o, status_o, tag_o}   = w_pk;
        assign busy_o                        = 1'b0;
    end else begin : g_pipe
        logic [NumPipeRegs-1:0]         r_vld_pipe;
        logic [NumPipeRegs-1:0][DW-1:0] r_data;
        logic [NumPipeRegs:0]           w_vin;
        logic [NumPipeRegs:0][DW-1:0]   w_din;
        logic [NumPipeRegs-1:0]         w_rdy;
        logic                           w_acc;

        // Element i feeds stage i; the last element is the output.
        assign w_vin = {r_vld_pipe, in_valid_i};
        assign w_din = {r_data, w_pk};

        // A stage can load if it or any stage downstream has a free slot,
        // folded back from the output so there is no combinational loop.
        always_comb begin
            w_acc = out_ready_i;
            w_rdy = '0;
            for (int i = NumPipeRegs - 1; i >= 0; i--) begin
                w_acc    = w_acc | ~r_vld_pipe[i];
                w_rdy[i] = w_acc;
            end
        end

        // Stage registers: advance when ready, hold when stalled, flush kills valids.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_vld_pipe <= '0;
                r_data     <= '0;
            end else begin
                for (int i = 0; i < NumPipeRegs; i++) begin
                    if (flush_i)       r_vld_pipe[i] <= 1'b0;
                    else if (w_rdy[i]) r_vld_pipe[i] <= w_vin[i];
                    if (w_rdy[i] && w_vin[i]) r_data[i] <= w_din[i];
                end
            end
        end

        assign in_ready_o                  = w_rdy[0];
        assign out_valid_o                 = w_vin[NumPipeRegs];
        assign {result_o, status_o, tag_o} = w_din[NumPipeRegs];
        assign busy_o                      = |r_vld_pipe;
    end

endmodule

// File: tb/tb_fpnew_result_packer.sv
// Bench for fpnew_result_packer: FP32 into a 64-bit word, one instance with one
// pipeline stage (directed + randomized against a reference model) and one with
// two stages (stall capacity, ordering, flush). Both see a mid-stream reset.
module tb_fpnew_result_packer;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
        int          cls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        sign;
    logic [8:0]  expo;
    logic [22:0] man;
    logic [1:0]  kind;
    logic [2:0]  rnd;
    logic [3:0]  tag;

    logic        a_vld, a_irdy, a_ovld, a_rdy, a_busy;
    logic [63:0] a_res;
    logic [4:0]  a_st;
    logic [3:0]  a_tag;
    logic        b_vld, b_irdy, b_ovld, b_rdy, b_busy;
    logic [63:0] b_res;
    logic [4:0]  b_st;
    logic [3:0]  b_tag;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fpnew_result_packer #(.FpFormat(0), .Width(64), .NumPipeRegs(1), .TagWidth(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(a_vld), .in_ready_o(a_irdy),
        .sign_i(sign), .exponent_i(expo), .mantissa_i(man), .kind_i(kind),
        .rnd_mode_i(rnd), .tag_i(tag),
        .out_valid_o(a_ovld), .out_ready_i(a_rdy),
        .result_o(a_res), .status_o(a_st), .tag_o(a_tag), .busy_o(a_busy)
    );

    fpnew_result_packer #(.FpFormat(0), .Width(64), .NumPipeRegs(2), .TagWidth(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(b_vld), .in_ready_o(b_irdy),
        .sign_i(sign), .exponent_i(expo), .mantissa_i(man), .kind_i(kind),
        .rnd_mode_i(rnd), .tag_i(tag),
        .out_valid_o(b_ovld), .out_ready_i(b_rdy),
        .result_o(b_res), .status_o(b_st), .tag_o(b_tag), .busy_o(b_busy)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: FP32 fields assembled arithmetically, boxed with 0xFFFFFFFF.
    function automatic exp_t ref_pack(input logic s, input int unsigned e, input int unsigned m,
                                      input int unsigned k, input int unsigned rm, input logic [3:0] tg);
        exp_t x;
        int unsigned r;
        bit inf;
        longint unsigned sb;
        sb    = s ? 64'h8000_0000 : 64'h0;
        x.res = 64'hFFFF_FFFF_0000_0000;
        x.st  = 5'd0;
        x.tag = tg;
        x.cls = 0;
        case (k)
            1: begin x.res = x.res | sb; x.cls = 1; end
            2: begin x.res = x.res | sb | 64'h7F80_0000; x.cls = 2; end
            3: begin x.res = x.res | 64'h7FC0_0000; x.cls = 3; end
            default: begin
                if (e >= 255) begin
                    x.st  = 5'h05;
                    r     = (rm > 4) ? 0 : rm;
                    inf   = (r == 0) || (r == 4) || (r == 3 && !s) || (r == 2 && s);
                    x.res = x.res | sb | (inf ? 64'h7F80_0000 : 64'h7F7F_FFFF);
                    x.cls = inf ? 2 : 0;
                end else begin
                    x.res = x.res | sb | (longint'(e) << 23) | longint'(m);
                    x.cls = (e == 0 && m == 0) ? 1 : 0;
                end
            end
        endcase
        return x;
    endfunction

    // Classifier view of a boxed FP32 word: 0=number 1=zero 2=inf 3=nan.
    function automatic int classify(input logic [63:0] w);
        logic [7:0]  e;
        logic [22:0] m;
        e = w[30:23];
        m = w[22:0];
        if (e == 8'hFF) return (m != 0) ? 3 : 2;
        if (e == 8'h00 && m == 0) return 1;
        return 0;
    endfunction

    task automatic set_in(input logic s, input logic [8:0] e, input logic [22:0] m,
                          input logic [1:0] k, input logic [2:0] rm, input logic [3:0] tg);
        sign = s; expo = e; man = m; kind = k; rnd = rm; tag = tg;
    endtask

    task automatic rand_in(input logic [3:0] tg);
        logic [8:0] e;
        case ($urandom_range(0, 5))
            0:       e = 9'd0;
            1:       e = 9'd254;
            2:       e = 9'd255;
            3:       e = 9'($urandom_range(256, 511));
            default: e = 9'($urandom_range(1, 254));
        endcase
        set_in(1'($urandom), e, (($urandom % 4) == 0) ? 23'd0 : 23'($urandom),
               2'($urandom), 3'($urandom), tg);
    endtask

    // One transaction through the 1-stage instance; expects it the next cycle.
    task automatic dir_a(input string nm, input logic s, input logic [8:0] e, input logic [22:0] m,
                         input logic [1:0] k, input logic [2:0] rm, input logic [3:0] tg,
                         input logic [63:0] xres, input logic [4:0] xst);
        set_in(s, e, m, k, rm, tg);
        a_vld = 1'b1;
        a_rdy = 1'b1;
        @(posedge clk); #1;
        a_vld = 1'b0;
        #1;
        chk({nm, "_vld"}, a_ovld, 1'b1);
        chk({nm, "_res"}, a_res, xres);
        chk({nm, "_st"}, a_st, xst);
        chk({nm, "_tag"}, a_tag, tg);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        exp_t q[$];
        exp_t x;
        int   tq[$];
        int   acc, got;

        rst_n = 1'b0; flush = 1'b0;
        a_vld = 1'b0; a_rdy = 1'b0; b_vld = 1'b0; b_rdy = 1'b0;
        set_in(1'b0, 9'd0, 23'd0, 2'd0, 3'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovld", a_ovld, 1'b0);
        chk("rst_res", a_res, 64'd0);
        chk("rst_st", a_st, 5'd0);
        chk("rst_tag", a_tag, 4'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_b_ovld", b_ovld, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_irdy", a_irdy, 1'b1);
        @(posedge clk); #1;

        // Directed encodings.
        dir_a("one",     1'b0, 9'h07F, 23'd0,      2'd0, 3'd0, 4'd3, 64'hFFFFFFFF_3F800000, 5'h00);
        dir_a("nan",     1'b1, 9'h000, 23'h12345,  2'd3, 3'd0, 4'd4, 64'hFFFFFFFF_7FC00000, 5'h00);
        dir_a("ninf",    1'b1, 9'h000, 23'd0,      2'd2, 3'd0, 4'd5, 64'hFFFFFFFF_FF800000, 5'h00);
        dir_a("ovf_rtz", 1'b0, 9'h100, 23'd0,      2'd0, 3'd1, 4'd6, 64'hFFFFFFFF_7F7FFFFF, 5'h05);
        dir_a("ovf_rne", 1'b0, 9'h100, 23'd0,      2'd0, 3'd0, 4'd7, 64'hFFFFFFFF_7F800000, 5'h05);
        dir_a("ovf_rup", 1'b1, 9'h100, 23'd0,      2'd0, 3'd3, 4'd8, 64'hFFFFFFFF_FF7FFFFF, 5'h05);
        dir_a("nzero",   1'b1, 9'h055, 23'h1,      2'd1, 3'd0, 4'd9, 64'hFFFFFFFF_80000000, 5'h00);
        dir_a("e255rdn", 1'b0, 9'h0FF, 23'h1,      2'd0, 3'd2, 4'hA, 64'hFFFFFFFF_7F7FFFFF, 5'h05);
        dir_a("rm7",     1'b1, 9'h1FF, 23'h1,      2'd0, 3'd7, 4'hB, 64'hFFFFFFFF_FF800000, 5'h00 | 5'h05);
        dir_a("maxn",    1'b1, 9'h0FE, 23'h7FFFFF, 2'd0, 3'd0, 4'hC, 64'hFFFFFFFF_FF7FFFFF, 5'h00);
        dir_a("subn",    1'b0, 9'h000, 23'h00ABC,  2'd0, 3'd1, 4'hD, 64'hFFFFFFFF_00000ABC, 5'h00);

        // Randomized traffic with back-pressure and occasional flush.
        b_rdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rand_in(4'($urandom));
            a_vld = ($urandom % 4) != 0;
            a_rdy = ($urandom % 3) != 0;
            flush = ($urandom % 32) == 0;
            #1;
            chk("r_ovld", a_ovld, q.size() != 0);
            chk("r_busy", a_busy, q.size() != 0);
            chk("r_irdy", a_irdy, (q.size() == 0) || a_rdy);
            if (q.size() != 0 && a_rdy) begin
                x = q.pop_front();
                chk("r_res", a_res, x.res);
                chk("r_st", a_st, x.st);
                chk("r_tag", a_tag, x.tag);
                chk("r_box", a_res[63:32], 32'hFFFF_FFFF);
                chk("r_cls", 64'(classify(a_res)), 64'(x.cls));
            end
            if (flush) q.delete();
            else if (a_vld && a_irdy) q.push_back(ref_pack(sign, expo, man, kind, rnd, tag));
            @(posedge clk); #1;
        end
        flush = 1'b0; a_vld = 1'b0; a_rdy = 1'b1;
        @(posedge clk); #1;
        chk("r_drain", a_ovld, 1'b0);
        q.delete();

        // Two-stage instance: stalled output holds exactly two entries.
        b_rdy = 1'b0;
        acc   = 0;
        for (int i = 0; i < 5; i++) begin
            rand_in(4'(i + 1));
            b_vld = 1'b1;
            #1;
            if (b_irdy) begin
                acc++;
                tq.push_back(i + 1);
            end
            @(posedge clk); #1;
        end
        b_vld = 1'b0;
        #1;
        chk("stall_acc", acc, 2);
        chk("stall_irdy", b_irdy, 1'b0);
        chk("stall_busy", b_busy, 1'b1);
        chk("stall_ovld", b_ovld, 1'b1);
        b_rdy = 1'b1;
        got   = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (b_ovld) begin
                got++;
                if (tq.size() != 0) chk("order_tag", b_tag, 64'(tq.pop_front()));
                else chk("dup_out", b_ovld, 1'b0);
            end
            @(posedge clk); #1;
        end
        chk("drain_cnt", got, 2);
        chk("drain_busy", b_busy, 1'b0);

        // Flush with two entries in flight plus one offered the same cycle.
        b_rdy = 1'b0;
        b_vld = 1'b1;
        rand_in(4'hE);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("fl_busy0", b_busy, 1'b1);
        chk("fl_ovld0", b_ovld, 1'b1);
        chk("fl_full", b_irdy, 1'b0);
        b_rdy = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        b_vld = 1'b0;
        #1;
        chk("fl_ovld", b_ovld, 1'b0);
        chk("fl_busy", b_busy, 1'b0);
        @(posedge clk); #1;
        chk("fl_drop", b_ovld, 1'b0);

        // Asynchronous reset while both instances hold data.
        set_in(1'b1, 9'h080, 23'h5A5A5, 2'd0, 3'd0, 4'hF);
        a_vld = 1'b1; a_rdy = 1'b0;
        b_vld = 1'b1; b_rdy = 1'b0;
        @(posedge clk); #1;
        a_vld = 1'b0; b_vld = 1'b0;
        #1;
        chk("mr_pre", a_ovld, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_a_ovld", a_ovld, 1'b0);
        chk("mr_a_res", a_res, 64'd0);
        chk("mr_a_st", a_st, 5'd0);
        chk("mr_a_tag", a_tag, 4'd0);
        chk("mr_a_busy", a_busy, 1'b0);
        chk("mr_b_ovld", b_ovld, 1'b0);
        chk("mr_b_res", b_res, 64'd0);
        chk("mr_b_busy", b_busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mr_a_irdy", a_irdy, 1'b1);
        chk("mr_b_irdy", b_irdy, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
